mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit with HI/LO registers, instantiated beside the ALU in the execute stage of the pipelined MIPS core. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support at a parametrised operand width. The block exposes a busy flag so the hazard unit can stall MFHI/MFLO and back-to-back multiply/divide instructions. In-flight operations can be cancelled without corrupting HI/LO.

## Interface
- WIDTH, 32: operand, HI and LO width; any even value ≥ 4.
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- StartE  in  1  launch the operation in MdOpE; sampled on the rising edge
- MdOpE  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op)
- SrcAE  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- SrcBE  in  WIDTH  rt operand (divisor / multiplier)
- CancelE  in  1  abort the in-flight operation (flush)
- MdBusyE  out  1  operation in progress; combinational from state
- MdDoneM  out  1  one-cycle pulse; HI/LO updated by a MULT/DIV operation
- HiOut  out  WIDTH  HI register
- LoOut  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX. The block drives MdBusyE = (state != IDLE).
- IDLE with StartE=1 and a MULT/DIV op:
  - Latch the absolute values of the operands. Signed ops take the two's-complement magnitude; unsigned ops take the raw value.
  - Latch the sign flags and the op.
  - Load the counter with WIDTH-1 and go to RUN.
- RUN, one step per cycle; the counter decrements and FIX is entered after the step with counter = 0:
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring algorithm with a WIDTH+1-bit partial remainder.
- FIX:
  - Apply signs. A signed product is negated when the operand signs differ. A signed quotient is negated when the signs differ. A signed remainder takes the sign of the dividend.
  - Write HI and LO. For multiply, HI = product[2W-1:W] and LO = product[W-1:0]. For divide, LO = quotient and HI = remainder.
  - Go to IDLE.
- Divide by zero: HI = dividend as supplied (SrcAE, unmodified), LO = all ones. Latency is unchanged; this applies to both signed and unsigned ops.
- Signed overflow (most-negative ÷ -1): LO = most-negative, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- MTHI/MTLO in IDLE: write HiOut or LoOut from SrcAE on the start edge. These ops never set busy and do not pulse MdDoneM.
- StartE while busy is ignored; the hazard unit is responsible for stalling. Reserved ops are ignored.
- CancelE at an edge:
  - The state returns to IDLE, HI/LO are unchanged and no MdDoneM is produced.
  - CancelE takes priority over a simultaneous StartE, which is also dropped. This includes MTHI/MTLO.
- Reset low: state IDLE, counter 0, HiOut = LoOut = 0, MdBusyE = 0, MdDoneM = 0, all immediately (asynchronous).

## Timing
- StartE is sampled at edge T0. MdBusyE is high from just after T0 until the edge T0+WIDTH+1, a total of WIDTH+1 cycles: WIDTH RUN cycles plus 1 FIX cycle.
- HiOut/LoOut change at edge T0+WIDTH+1. MdDoneM is high for exactly the following cycle.
- Latency is identical for all MULT/DIV variants, operand values and divide-by-zero.
- MTHI/MTLO: HiOut/LoOut change at T0, with zero busy cycles.
- A new StartE is accepted at edge T0+WIDTH+1, the edge on which busy falls. The next result therefore lands WIDTH+1 edges later with no bubble.
- HiOut/LoOut are registered outputs. There is no bypass from an in-flight result.

## Test plan
- WIDTH=32, MULT SrcAE=FFFFFFFD (-3), SrcBE=00000007 -> MdBusyE high for 33 cycles, then HiOut=FFFFFFFF, LoOut=FFFFFFEB, and one MdDoneM pulse.
- MULTU FFFFFFFF × FFFFFFFF -> HiOut=FFFFFFFE, LoOut=00000001. DIV FFFFFFF9 (-7) ÷ 00000002 -> LoOut=FFFFFFFD, HiOut=FFFFFFFF.
- DIVU 00000007 ÷ 0 -> HiOut=00000007, LoOut=FFFFFFFF after 33 cycles. DIV 80000000 ÷ FFFFFFFF -> LoOut=80000000, HiOut=00000000.
- With HI/LO = 1/2, start MULT 5×5:
  - A StartE DIVU at cycle 5 is ignored.
  - CancelE at cycle 10 -> busy drops at the next edge, HI/LO stay 1/2, no MdDoneM.
  - MTHI 00001234 on the following edge -> HiOut=00001234 with no busy.
- Back-to-back: MULTU 3×4 is followed by DIVU 100÷7 started on the edge busy falls -> LoOut=0000000C, then 33 edges later LoOut=0000000E, HiOut=00000002.
- Reset pulled low mid-DIV -> MdBusyE=0 and HiOut=LoOut=0 immediately, no MdDoneM. At WIDTH=8, MULT 80×80 -> busy 9 cycles, HiOut=40, LoOut=00.

Source files
------------

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are applied in FIX.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             StartE,
    input  logic [2:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             CancelE,
    output logic             MdBusyE,
    output logic             MdDoneM,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, stateNext;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem, opB, magA, magB, quoFix, remFix;
    logic [WIDTH:0] mulSum, divShift, divDiff;
    logic [2*WIDTH-1:0] prodFix;
    logic isDiv, negRes, negRem, divZero, isSigned, mdStart, mtStart;

    assign MdBusyE = state != IDLE;

    always_comb begin
        isSigned = !MdOpE[0];
        // a new MULT/DIV may also launch on the FIX edge, so results stream without a bubble
        mdStart = StartE && !CancelE && !MdOpE[2] && (state == IDLE || state == FIX);
        mtStart = StartE && !CancelE && MdOpE[2:1] == 2'b10 && state == IDLE;
        magA = (isSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        magB = (isSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
        divShift = {rem, acc[WIDTH-1]};
        divDiff = divShift - {1'b0, opB};
        prodFix = negRes ? -acc : acc;
        quoFix = divZero ? '1 : (negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        remFix = negRem ? -rem : rem;
    end

    always_comb begin
        stateNext = CancelE ? IDLE :
                    state == RUN ? (cnt == '0 ? FIX : RUN) :
                    mdStart ? RUN : IDLE;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else state <= stateNext;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opB     <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            HiOut   <= '0;
            LoOut   <= '0;
            MdDoneM <= 1'b0;
        end else begin
            MdDoneM <= state == FIX && !CancelE;
            if (mdStart) begin
                cnt     <= CW'(WIDTH - 1);
                isDiv   <= MdOpE[1];
                negRes  <= isSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                negRem  <= isSigned && SrcAE[WIDTH-1];
                divZero <= SrcBE == '0;
                opB     <= MdOpE[1] ? magB : magA;
                acc     <= {{WIDTH{1'b0}}, MdOpE[1] ? magA : magB};
                rem     <= '0;
            end else if (state == RUN && !CancelE) begin
                cnt <= cnt - CW'(1);
                if (isDiv) begin
                    acc[WIDTH-1:0] <= {acc[WIDTH-2:0], !divDiff[WIDTH]};
                    rem <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
                end else begin
                    acc <= {mulSum, acc[WIDTH-1:1]};
                end
            end
            if (state == FIX && !CancelE) begin
                HiOut <= isDiv ? remFix : prodFix[2*WIDTH-1:WIDTH];
                LoOut <= isDiv ? quoFix : prodFix[WIDTH-1:0];
            end else if (mtStart) begin
                if (MdOpE[0]) LoOut <= SrcAE;
                else HiOut <= SrcAE;
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against a cycle-level arithmetic model.
module tb_mdu;
    logic CLK = 1'b0, Reset = 1'b1, StartE = 1'b0, CancelE = 1'b0;
    logic [2:0] MdOpE = '0;
    logic [31:0] SrcAE = '0, SrcBE = '0;
    logic MdBusyE, MdDoneM;
    logic [31:0] HiOut, LoOut;
    logic s8Start = 1'b0;
    logic [2:0] s8Op = '0;
    logic [7:0] s8A = '0, s8B = '0;
    logic b8, d8;
    logic [7:0] h8, l8;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [31:0] hi, lo, ph, pl;
        int rem;
        logic done;
    } model_t;
    model_t m;

    always #5 CLK = ~CLK;

    mdu #(.WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset), .StartE(StartE), .MdOpE(MdOpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .CancelE(CancelE), .MdBusyE(MdBusyE), .MdDoneM(MdDoneM), .HiOut(HiOut), .LoOut(LoOut)
    );

    mdu #(.WIDTH(8)) dut8 (
        .CLK(CLK), .Reset(Reset), .StartE(s8Start), .MdOpE(s8Op), .SrcAE(s8A), .SrcBE(s8B),
        .CancelE(1'b0), .MdBusyE(b8), .MdDoneM(d8), .HiOut(h8), .LoOut(l8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {HI, LO} from plain 64-bit arithmetic
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = '0;
        if (op == 3'd0) r = sa * sb;
        else if (op == 3'd1) r = ua * ub;
        else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (op == 3'd2) r = {32'(sa % sb), 32'(sa / sb)};
        else if (op == 3'd3) r = {a % b, a / b};
        return r;
    endfunction

    function automatic model_t step(input model_t s, input logic st, input logic cn,
                                    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        model_t n;
        bit wasIdle;
        n = s;
        wasIdle = s.rem == 0;
        n.done = 1'b0;
        if (cn) begin
            n.rem = 0;
            return n;
        end
        if (n.rem > 0) begin
            n.rem--;
            if (n.rem == 0) begin
                n.hi = n.ph;
                n.lo = n.pl;
                n.done = 1'b1;
            end
        end
        if (st && n.rem == 0) begin
            if (!op[2]) begin
                {n.ph, n.pl} = calc(op, a, b);
                n.rem = 33;
            end else if (wasIdle && op == 3'd4) n.hi = a;
            else if (wasIdle && op == 3'd5) n.lo = a;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) m <= '0;
        else m <= step(m, StartE, CancelE, MdOpE, SrcAE, SrcBE);
    end

    always @(negedge CLK) begin
        chk("busy", MdBusyE, m.rem != 0);
        chk("done", MdDoneM, m.done);
        chk("hi", HiOut, m.hi);
        chk("lo", LoOut, m.lo);
    end

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busyCyc, output int doneCnt);
        StartE = 1'b1; MdOpE = op; SrcAE = a; SrcBE = b;
        @(negedge CLK);
        StartE = 1'b0;
        busyCyc = 0;
        doneCnt = 0;
        while (MdBusyE && busyCyc < 100) begin
            busyCyc++;
            @(negedge CLK);
            doneCnt += int'(MdDoneM);
        end
        @(negedge CLK);
        doneCnt += int'(MdDoneM);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        StartE = 1'b1; MdOpE = op; SrcAE = a;
        @(negedge CLK);
        StartE = 1'b0;
        chk("mtBusy", MdBusyE, 0);
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, dc;
        #1 Reset = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        chk("rstBusy", MdBusyE, 0);
        chk("rstHi", HiOut, 0);
        chk("rstLo", LoOut, 0);

        runOp(3'd0, 32'hFFFF_FFFD, 32'd7, bc, dc);
        chk("multBusyCyc", bc, 33);
        chk("multDones", dc, 1);
        chk("multHi", HiOut, 32'hFFFF_FFFF);
        chk("multLo", LoOut, 32'hFFFF_FFEB);
        chk("modelMultLo", m.lo, 32'hFFFF_FFEB);

        runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        chk("multuHi", HiOut, 32'hFFFF_FFFE);
        chk("multuLo", LoOut, 32'h0000_0001);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc);
        chk("divLo", LoOut, 32'hFFFF_FFFD);
        chk("divHi", HiOut, 32'hFFFF_FFFF);
        chk("modelDivHi", m.hi, 32'hFFFF_FFFF);
        runOp(3'd3, 32'd7, 32'd0, bc, dc);
        chk("divzBusyCyc", bc, 33);
        chk("divzHi", HiOut, 32'h7);
        chk("divzLo", LoOut, 32'hFFFF_FFFF);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd0, bc, dc);
        chk("sdivzHi", HiOut, 32'hFFFF_FFF9);
        chk("sdivzLo", LoOut, 32'hFFFF_FFFF);
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        chk("ovfLo", LoOut, 32'h8000_0000);
        chk("ovfHi", HiOut, 32'h0);

        mt(3'd4, 32'd1);
        mt(3'd5, 32'd2);
        chk("mtHi", HiOut, 32'd1);
        chk("mtLo", LoOut, 32'd2);
        StartE = 1'b1; MdOpE = 3'd0; SrcAE = 32'd5; SrcBE = 32'd5;
        @(negedge CLK);
        StartE = 1'b0;
        repeat (3) @(negedge CLK);
        StartE = 1'b1; MdOpE = 3'd3; SrcAE = 32'd100; SrcBE = 32'd7;
        @(negedge CLK);
        StartE = 1'b0;
        repeat (4) @(negedge CLK);
        CancelE = 1'b1;
        @(negedge CLK);
        CancelE = 1'b0;
        chk("cancelBusy", MdBusyE, 0);
        chk("cancelHi", HiOut, 32'd1);
        chk("cancelLo", LoOut, 32'd2);
        mt(3'd4, 32'h1234);
        chk("mthiAfterCancel", HiOut, 32'h1234);
        dc = 0;
        repeat (40) begin
            @(negedge CLK);
            dc += int'(MdDoneM);
        end
        chk("cancelNoDone", dc, 0);
        chk("cancelLoKept", LoOut, 32'd2);

        StartE = 1'b1; MdOpE = 3'd1; SrcAE = 32'd3; SrcBE = 32'd4;
        @(negedge CLK);
        StartE = 1'b0;
        repeat (32) @(negedge CLK);
        StartE = 1'b1; MdOpE = 3'd3; SrcAE = 32'd100; SrcBE = 32'd7;
        @(negedge CLK);
        StartE = 1'b0;
        chk("b2bFirstLo", LoOut, 32'hC);
        chk("b2bBusy", MdBusyE, 1);
        repeat (33) @(negedge CLK);
        chk("b2bSecondLo", LoOut, 32'hE);
        chk("b2bSecondHi", HiOut, 32'h2);

        StartE = 1'b1; MdOpE = 3'd2; SrcAE = 32'hFFFF_FFF9; SrcBE = 32'd2;
        @(negedge CLK);
        StartE = 1'b0;
        repeat (10) @(negedge CLK);
        #2 Reset = 1'b0;
        #1;
        chk("asyncRstBusy", MdBusyE, 0);
        chk("asyncRstHi", HiOut, 0);
        chk("asyncRstLo", LoOut, 0);
        chk("asyncRstDone", MdDoneM, 0);
        @(negedge CLK);
        Reset = 1'b1;

        s8Start = 1'b1; s8Op = 3'd0; s8A = 8'h80; s8B = 8'h80;
        @(negedge CLK);
        s8Start = 1'b0;
        bc = 0;
        while (b8 && bc < 50) begin
            bc++;
            @(negedge CLK);
        end
        chk("w8BusyCyc", bc, 9);
        chk("w8Hi", h8, 8'h40);
        chk("w8Lo", l8, 8'h00);
        chk("w8Done", d8, 1);

        repeat (4000) begin
            StartE = $urandom_range(0, 3) == 0;
            MdOpE = 3'($urandom_range(0, 7));
            if (m.rem != 0) MdOpE[2] = 1'b0;
            SrcAE = rnd();
            SrcBE = rnd();
            CancelE = $urandom_range(0, 99) == 0;
            @(negedge CLK);
        end
        StartE = 1'b0;
        CancelE = 1'b0;
        repeat (40) @(negedge CLK);
        chk("finalIdle", MdBusyE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
